sensor_timing_gen: RTL and testbench

- Synthesizable, parametrised parallel-sensor timing and pattern generator for the sensor_if stream path.
- Produces fval/lval/pixel data in the style of the MT9P031 channel.
- Generalises the fixed single-channel sensor model to N channels per clock, selectable test patterns, and pause-after-frame.
- Adds dummy-line lval during frame blanking (continue_lval), so stream_sync/sync_buffer can be exercised on silicon and in simulation without a behavioural model.

---
 rtl/sensor_if_pkg.sv | 19 +
 rtl/sensor_pattern_gen.sv | 39 +++
 rtl/sensor_timing_gen.sv | 208 ++++++++++++++++++++
 tb/tb_sensor_timing_gen.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_if_pkg.sv
// Shared definitions for the sensor_if stream path: timing FSM states and
// test-pattern selector codes.
package sensor_if_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FRONT = 3'd1,
    S_LINE  = 3'd2,
    S_LHIDE = 3'd3,
    S_BACK  = 3'd4,
    S_FHIDE = 3'd5
  } state_e;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_MOVE  = 2'd2;
  localparam logic [1:0] PAT_FIXED = 2'd3;

endpackage

// File: rtl/sensor_pattern_gen.sv
// Combinational per-channel pixel value from column, line and frame counters.
// The parent registers the result and blanks it outside active lines.
module sensor_pattern_gen
  import sensor_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned CHANNEL_NUM = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic [CNT_WIDTH-1:0]              x,
  input  logic [CNT_WIDTH-1:0]              y,
  input  logic [CNT_WIDTH-1:0]              f,
  input  logic [1:0]                        pattern,
  input  logic [DATA_WIDTH-1:0]             fixed_value,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix
);

  for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] ramp;
    logic [DATA_WIDTH-1:0] val;

    // Only the low DATA_WIDTH bits of each term matter after truncation.
    assign ramp = DATA_WIDTH'(x) * DATA_WIDTH'(CHANNEL_NUM) + DATA_WIDTH'(k);

    always_comb begin
      val = '0;
      unique case (pattern)
        PAT_HRAMP: val = ramp;
        PAT_VRAMP: val = DATA_WIDTH'(y);
        PAT_MOVE:  val = ramp + DATA_WIDTH'(f);
        PAT_FIXED: val = fixed_value;
        default:   val = '0;
      endcase
    end

    assign pix[k*DATA_WIDTH +: DATA_WIDTH] = val;
  end

endmodule

// File: rtl/sensor_timing_gen.sv
// Parallel-sensor fval/lval timing and test-pattern generator with shadowed
// configuration, pause-after-frame and optional dummy lines in frame blanking.
module sensor_timing_gen
  import sensor_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned CHANNEL_NUM = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_pause_en,
  input  logic                              i_continue_lval,
  input  logic [CNT_WIDTH-1:0]              iv_width,
  input  logic [CNT_WIDTH-1:0]              iv_line_hide,
  input  logic [CNT_WIDTH-1:0]              iv_height,
  input  logic [CNT_WIDTH-1:0]              iv_frame_hide,
  input  logic [CNT_WIDTH-1:0]              iv_front_porch,
  input  logic [CNT_WIDTH-1:0]              iv_back_porch,
  input  logic [1:0]                        iv_pattern,
  input  logic [DATA_WIDTH-1:0]             iv_fixed_value,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_frame_done,
  output logic [CNT_WIDTH-1:0]              ov_frame_cnt
);

  localparam logic [CNT_WIDTH-1:0] One = CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   y_q, y_d;
  logic [CNT_WIDTH-1:0]   dum_cnt_q, dum_cnt_d;
  logic                   dum_hi_q, dum_hi_d;

  logic [CNT_WIDTH-1:0]   sh_width, sh_lhide, sh_height, sh_fhide, sh_front, sh_back;
  logic [1:0]             sh_pattern;
  logic [DATA_WIDTH-1:0]  sh_fixed;

  logic                              fval_q, lval_q, done_q;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_q;
  logic [CNT_WIDTH-1:0]              fcnt_q;

  logic                              start, load;
  logic [CNT_WIDTH-1:0]              fh_last;
  logic                              fval_n, lval_n;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_n, pat_pix;

  assign start   = !i_pause_en && (iv_width != '0) && (iv_height != '0);
  assign fh_last = (sh_fhide == '0) ? '0 : sh_fhide - One;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + One;
    y_d       = '0;
    load      = 1'b0;
    dum_cnt_d = '0;
    dum_hi_d  = 1'b1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          load    = 1'b1;
          state_d = (iv_front_porch == '0) ? S_LINE : S_FRONT;
        end
      end
      S_FRONT: begin
        if (cnt_q == sh_front - One) begin
          cnt_d   = '0;
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        y_d = y_q;
        if (cnt_q == sh_width - One) begin
          cnt_d = '0;
          if (y_q == sh_height - One) begin
            state_d = (sh_back == '0) ? S_FHIDE : S_BACK;
          end else begin
            y_d = y_q + One;
            // Zero line blanking chains lines back to back with lval held high.
            if (sh_lhide != '0) state_d = S_LHIDE;
          end
        end
      end
      S_LHIDE: begin
        y_d = y_q;
        if (cnt_q == sh_lhide - One) begin
          cnt_d   = '0;
          state_d = S_LINE;
        end
      end
      S_BACK: begin
        if (cnt_q == sh_back - One) begin
          cnt_d   = '0;
          state_d = S_FHIDE;
        end
      end
      S_FHIDE: begin
        dum_cnt_d = dum_cnt_q + One;
        dum_hi_d  = dum_hi_q;
        if (dum_hi_q && (dum_cnt_q == sh_width - One)) begin
          dum_cnt_d = '0;
          dum_hi_d  = (sh_lhide == '0);
        end else if (!dum_hi_q && (dum_cnt_q == sh_lhide - One)) begin
          dum_cnt_d = '0;
          dum_hi_d  = 1'b1;
        end
        if (cnt_q >= fh_last) begin
          cnt_d = '0;
          if (start) begin
            load    = 1'b1;
            state_d = (iv_front_porch == '0) ? S_LINE : S_FRONT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      y_q       <= '0;
      dum_cnt_q <= '0;
      dum_hi_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      dum_cnt_q <= dum_cnt_d;
      dum_hi_q  <= dum_hi_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_width   <= '0;
      sh_lhide   <= '0;
      sh_height  <= '0;
      sh_fhide   <= '0;
      sh_front   <= '0;
      sh_back    <= '0;
      sh_pattern <= PAT_HRAMP;
      sh_fixed   <= '0;
    end else if (load) begin
      sh_width   <= iv_width;
      sh_lhide   <= iv_line_hide;
      sh_height  <= iv_height;
      sh_fhide   <= iv_frame_hide;
      sh_front   <= iv_front_porch;
      sh_back    <= iv_back_porch;
      sh_pattern <= iv_pattern;
      sh_fixed   <= iv_fixed_value;
    end
  end

  sensor_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHANNEL_NUM(CHANNEL_NUM),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_pattern (
    .x          (cnt_q),
    .y          (y_q),
    .f          (fcnt_q),
    .pattern    (sh_pattern),
    .fixed_value(sh_fixed),
    .pix        (pat_pix)
  );

  // Outputs are a registered view of the current state, so they lag it by one clock.
  assign fval_n = (state_q == S_FRONT) || (state_q == S_LINE) ||
                  (state_q == S_LHIDE) || (state_q == S_BACK);
  assign lval_n = (state_q == S_LINE) ||
                  ((state_q == S_FHIDE) && i_continue_lval && dum_hi_q);
  assign pix_n  = (state_q == S_LINE) ? pat_pix : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      pix_q  <= '0;
      done_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      fval_q <= fval_n;
      lval_q <= lval_n;
      pix_q  <= pix_n;
      done_q <= fval_q && !fval_n;
      if (fval_q && !fval_n) fcnt_q <= fcnt_q + One;
    end
  end

  assign o_fval       = fval_q;
  assign o_lval       = lval_q;
  assign ov_pix_data  = pix_q;
  assign o_frame_done = done_q;
  assign ov_frame_cnt = fcnt_q;

endmodule

// File: tb/tb_sensor_timing_gen.sv
// Scoreboard bench: stimulus queues expected pixels, frame lengths and blanking
// gaps; a negedge monitor pops and compares whatever the DUT presents.
module tb_sensor_timing_gen;

  typedef struct packed {
    logic [23:0] pix;
    logic        fval;
  } pix_t;

  typedef struct packed {
    logic [31:0] len;
    logic [31:0] cnt;
  } frm_t;

  typedef struct packed {
    logic [3:0]  pix;
    logic [15:0] cnt;
  } pixb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause_en = 1'b1;
  logic        continue_lval = 1'b0;
  logic [15:0] width = '0, line_hide = '0, height = '0, frame_hide = '0;
  logic [15:0] front_porch = '0, back_porch = '0;
  logic [1:0]  pattern = '0;
  logic [11:0] fixed_value = '0;

  logic        fval, lval, frame_done;
  logic [23:0] pix;
  logic [15:0] frame_cnt;
  logic        fval_b, lval_b, frame_done_b;
  logic [3:0]  pix_b;
  logic [15:0] frame_cnt_b;

  int checks = 0;
  int failures = 0;

  pix_t  exp_pix[$];
  frm_t  exp_frm[$];
  int    exp_gap[$];
  pixb_t exp_b[$];

  logic mon_en = 1'b1;
  logic b_en = 1'b0;
  logic prev_fval = 1'b0;
  logic gap_armed = 1'b0;
  int   flen = 0, gap_len = 0, rise_seen = 0, done_seen = 0;

  always #5 clk = ~clk;

  sensor_timing_gen #(.DATA_WIDTH(12), .CHANNEL_NUM(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .i_pause_en(pause_en), .i_continue_lval(continue_lval),
    .iv_width(width), .iv_line_hide(line_hide), .iv_height(height),
    .iv_frame_hide(frame_hide), .iv_front_porch(front_porch), .iv_back_porch(back_porch),
    .iv_pattern(pattern), .iv_fixed_value(fixed_value),
    .o_fval(fval), .o_lval(lval), .ov_pix_data(pix), .o_frame_done(frame_done),
    .ov_frame_cnt(frame_cnt)
  );

  // Narrow single-channel instance, used for the 4-bit wrap of the moving ramp.
  sensor_timing_gen #(.DATA_WIDTH(4), .CHANNEL_NUM(1), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .i_pause_en(pause_en), .i_continue_lval(continue_lval),
    .iv_width(width), .iv_line_hide(line_hide), .iv_height(height),
    .iv_frame_hide(frame_hide), .iv_front_porch(front_porch), .iv_back_porch(back_porch),
    .iv_pattern(pattern), .iv_fixed_value(fixed_value[3:0]),
    .o_fval(fval_b), .o_lval(lval_b), .ov_pix_data(pix_b), .o_frame_done(frame_done_b),
    .ov_frame_cnt(frame_cnt_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin : mon
    pix_t  e;
    frm_t  r;
    pixb_t eb;
    int    g;
    if (reset) begin
      prev_fval = 1'b0;
      flen      = 0;
      gap_len   = 0;
      gap_armed = 1'b0;
      rise_seen = 0;
      done_seen = 0;
    end else begin
      if (mon_en) begin
        if (lval) begin
          if (exp_pix.size() == 0) fail_now("unexpected_lval");
          else begin
            e = exp_pix.pop_front();
            chk("pix_data", pix, e.pix);
            chk("lval_fval", fval, e.fval);
          end
        end
        if (b_en && lval_b) begin
          if (exp_b.size() == 0) fail_now("unexpected_lval_b");
          else begin
            eb = exp_b.pop_front();
            chk("pix_data_b", pix_b, eb.pix);
            chk("frame_cnt_b", frame_cnt_b, eb.cnt);
            chk("fval_b", fval_b, 1'b1);
            chk("frame_done_b", frame_done_b, 1'b0);
          end
        end
        if (fval && !prev_fval) begin
          if (gap_armed) begin
            if (exp_gap.size() == 0) fail_now("unexpected_frame_start");
            else begin
              g = exp_gap.pop_front();
              chk("fval_low_gap", gap_len, g);
            end
          end
          rise_seen++;
          flen = 0;
        end
        if (fval) flen++;
        if (!fval && prev_fval) begin
          if (exp_frm.size() == 0) fail_now("unexpected_frame_end");
          else begin
            r = exp_frm.pop_front();
            chk("fval_high_len", flen, r.len);
            chk("frame_done_at_fall", frame_done, 1'b1);
            chk("frame_cnt", frame_cnt, r.cnt);
          end
          done_seen++;
          gap_armed = 1'b1;
          gap_len   = 0;
        end else if (frame_done) begin
          fail_now("frame_done_without_fall");
        end
        if (!fval && gap_armed) gap_len++;
      end
      prev_fval = fval;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int w, input int lh, input int h, input int fr, input int bk,
                     input int fh, input int pat, input int fix, input logic cont);
    width         = 16'(w);
    line_hide     = 16'(lh);
    height        = 16'(h);
    front_porch   = 16'(fr);
    back_porch    = 16'(bk);
    frame_hide    = 16'(fh);
    pattern       = 2'(pat);
    fixed_value   = 12'(fix);
    continue_lval = cont;
  endtask

  // Expected frame: fval length, completed-frame count, and every active pixel.
  task automatic push_frame(input int w, input int lh, input int h, input int fr,
                            input int bk, input int pat, input int fix, input int f);
    frm_t  r;
    pix_t  e;
    pixb_t eb;
    int    v;
    r.len = 32'(fr + w * h + lh * (h - 1) + bk);
    r.cnt = 32'(f + 1);
    exp_frm.push_back(r);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        e.fval = 1'b1;
        e.pix  = '0;
        for (int k = 0; k < 2; k++) begin
          case (pat)
            0:       v = x * 2 + k;
            1:       v = y;
            2:       v = x * 2 + k + f;
            default: v = fix;
          endcase
          e.pix[k*12 +: 12] = v[11:0];
        end
        exp_pix.push_back(e);
        if (b_en) begin
          case (pat)
            0:       v = x;
            1:       v = y;
            2:       v = x + f;
            default: v = fix;
          endcase
          eb.pix = v[3:0];
          eb.cnt = 16'(f);
          exp_b.push_back(eb);
        end
      end
    end
  endtask

  task automatic push_dummy(input int w, input int lh, input int fh);
    pix_t e;
    e.pix  = '0;
    e.fval = 1'b0;
    for (int t = 0; t < fh; t++) if ((t % (w + lh)) < w) exp_pix.push_back(e);
  endtask

  task automatic wait_rise(input int n);
    for (int i = 0; i < 3000 && rise_seen < n; i++) tick();
    if (rise_seen < n) fail_now("timeout_waiting_fval_rise");
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 3000 && done_seen < n; i++) tick();
    if (done_seen < n) fail_now("timeout_waiting_frame_done");
  endtask

  task automatic run_frames(input int n);
    pause_en = 1'b0;
    wait_rise(n);
    pause_en = 1'b1;
    wait_done(n);
    repeat (60) tick();
  endtask

  task automatic finish_test(input string name);
    chk({name, "_leftover"}, exp_pix.size() + exp_frm.size() + exp_gap.size() + exp_b.size(), 0);
    exp_pix.delete();
    exp_frm.delete();
    exp_gap.delete();
    exp_b.delete();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    pause_en = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) tick();
    chk("reset_fval", fval, 1'b0);
    chk("reset_lval", lval, 1'b0);
    chk("reset_pix", pix, 24'h0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_frame_cnt", frame_cnt, 16'h0);

    // Basic frame, two channels, horizontal ramp.
    do_reset();
    cfg(4, 2, 3, 1, 2, 5, 0, 0, 1'b0);
    push_frame(4, 2, 3, 1, 2, 0, 0, 0);
    run_frames(1);
    finish_test("basic");

    // Pause asserted during line 2 of frame 0, then released.
    do_reset();
    cfg(4, 2, 3, 1, 2, 5, 0, 0, 1'b0);
    push_frame(4, 2, 3, 1, 2, 0, 0, 0);
    exp_gap.push_back(12);
    push_frame(4, 2, 3, 1, 2, 0, 0, 1);
    pause_en = 1'b0;
    wait_rise(1);
    repeat (8) tick();
    pause_en = 1'b1;
    wait_done(1);
    repeat (9) tick();
    chk("paused_fval_low", fval, 1'b0);
    chk("paused_rise_count", rise_seen, 1);
    pause_en = 1'b0;
    n = 0;
    while (n < 50 && !fval) begin
      tick();
      n++;
    end
    chk("release_to_fval", n, 2);
    pause_en = 1'b1;
    wait_done(2);
    repeat (60) tick();
    finish_test("pause");

    // Zero porches and blanking, vertical ramp.
    do_reset();
    cfg(4, 0, 3, 0, 0, 0, 1, 0, 1'b0);
    push_frame(4, 0, 3, 0, 0, 1, 0, 0);
    exp_gap.push_back(1);
    push_frame(4, 0, 3, 0, 0, 1, 0, 1);
    run_frames(2);
    finish_test("zero_edges");

    // Dummy lines during frame blanking, fixed pattern.
    do_reset();
    cfg(4, 2, 2, 1, 1, 20, 3, 12'hABC, 1'b1);
    push_frame(4, 2, 2, 1, 1, 3, 12'hABC, 0);
    push_dummy(4, 2, 20);
    exp_gap.push_back(20);
    push_frame(4, 2, 2, 1, 1, 3, 12'hABC, 1);
    push_dummy(4, 2, 20);
    run_frames(2);
    finish_test("continue_lval");

    // Width changed mid-frame takes effect on the next frame; moving ramp.
    do_reset();
    cfg(4, 1, 2, 1, 1, 2, 2, 0, 1'b0);
    push_frame(4, 1, 2, 1, 1, 2, 0, 0);
    exp_gap.push_back(2);
    push_frame(8, 1, 2, 1, 1, 2, 0, 1);
    pause_en = 1'b0;
    wait_rise(1);
    width = 16'd8;
    wait_rise(2);
    pause_en = 1'b1;
    wait_done(2);
    repeat (60) tick();
    finish_test("config_change");

    // Sixteen short frames; frame 15 wraps the 4-bit moving ramp.
    do_reset();
    b_en = 1'b1;
    cfg(2, 0, 1, 0, 0, 0, 2, 0, 1'b0);
    for (int f = 0; f < 16; f++) begin
      if (f > 0) exp_gap.push_back(1);
      push_frame(2, 0, 1, 0, 0, 2, 0, f);
    end
    run_frames(16);
    b_en = 1'b0;
    finish_test("wrap");

    // Asynchronous reset in the middle of a line.
    do_reset();
    cfg(4, 2, 3, 1, 2, 5, 0, 0, 1'b0);
    push_frame(4, 2, 3, 1, 2, 0, 0, 0);
    exp_gap.push_back(5);
    pause_en = 1'b0;
    wait_rise(2);
    mon_en = 1'b0;
    n = 0;
    while (n < 50 && !lval) begin
      tick();
      n++;
    end
    chk("pre_reset_lval", lval, 1'b1);
    chk("pre_reset_frame_cnt", frame_cnt, 16'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_fval", fval, 1'b0);
    chk("async_reset_lval", lval, 1'b0);
    chk("async_reset_pix", pix, 24'h0);
    chk("async_reset_frame_cnt", frame_cnt, 16'h0);
    finish_test("reset_pre");
    repeat (3) tick();
    mon_en = 1'b1;
    push_frame(4, 2, 3, 1, 2, 0, 0, 0);
    reset = 1'b0;
    n = 0;
    while (n < 50 && !fval) begin
      tick();
      n++;
    end
    chk("reset_release_to_fval", n, 2);
    pause_en = 1'b1;
    wait_done(1);
    repeat (60) tick();
    finish_test("reset_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
